// File: rtl/mem_access.sv
// Memory-access pipeline stage. Drives the data bus, absorbs wait states and
// timeouts, flags misaligned accesses and registers the MEM/WB payload.
module mem_access #(
   parameter int unsigned BUS_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        keep,
   input  logic        nop,
   input  logic [31:0] ALU_co_pype,
   input  logic [31:0] read_data2_pype2,
   input  logic [31:0] PCp4_pype2,
   input  logic [4:0]  WReg_pype2,
   input  logic [2:0]  writeback_control_pype2,
   input  logic [2:0]  funct3_pype2,
   input  logic [1:0]  MemRW_pype2,
   input  logic [1:0]  dsize_pype2,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] ALU_co_pype3,
   output logic [31:0] load_data_pype3,
   output logic [31:0] PCp4_pype3,
   output logic [4:0]  WReg_pype3,
   output logic [2:0]  writeback_control_pype3,
   output logic        mem_stall,
   output logic        mem_misalign,
   output logic        mem_bus_error,
   output logic [31:0] mem_fault_addr
);
   localparam int unsigned CNT_W = $clog2(BUS_TIMEOUT) + 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      rbuf_q, rbuf_d;
   logic             hold_err_q, hold_err_d;
   logic [31:0]      alu_q, alu_d, ld_q, ld_d, pc_q, pc_d, fault_q, fault_d;
   logic [4:0]       wreg_q, wreg_d;
   logic [2:0]       wbc_q, wbc_d;
   logic             mis_q, mis_d, bus_err_q, bus_err_d;

   logic        memop, misaligned, access, timeout, req, stall, bubble, mis_evt;
   logic [31:0] word;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ld_ext;

   // Request decode and timeout detection
   always_comb begin
      memop      = |MemRW_pype2;
      misaligned = ((dsize_pype2 == 2'b01) & ALU_co_pype[0]) |
                   ((dsize_pype2 == 2'b10) & (ALU_co_pype[1:0] != 2'b00));
      access     = memop & ~misaligned;
      timeout    = (state_q == S_WAIT) & ~dmem_ready &
                   (cnt_q >= CNT_W'(BUS_TIMEOUT - 1));
      mis_evt    = (state_q == S_IDLE) & memop & misaligned & ~keep;
   end

   // Bus FSM next state; HOLD parks a finished access while the hazard unit holds keep
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rbuf_d     = rbuf_q;
      hold_err_d = hold_err_q;
      req        = 1'b0;
      stall      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (access) begin
               req = 1'b1;
               if (dmem_ready) begin
                  rbuf_d = dmem_rdata;
                  if (keep) state_d = S_HOLD;
               end else begin
                  stall   = 1'b1;
                  state_d = S_WAIT;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         S_WAIT: begin
            if (dmem_ready) begin
               req     = 1'b1;
               rbuf_d  = dmem_rdata;
               cnt_d   = '0;
               state_d = keep ? S_HOLD : S_IDLE;
            end else if (timeout) begin
               cnt_d      = '0;
               hold_err_d = keep;
               state_d    = keep ? S_HOLD : S_IDLE;
            end else begin
               req   = 1'b1;
               stall = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (!keep) begin
               state_d    = S_IDLE;
               hold_err_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Store lane replication and strobes
   always_comb begin
      dmem_addr = {ALU_co_pype[31:2], 2'b00};
      dmem_we   = MemRW_pype2[0];
      case (dsize_pype2)
         2'b00: begin
            dmem_wdata = {4{read_data2_pype2[7:0]}};
            dmem_wstrb = 4'b0001 << ALU_co_pype[1:0];
         end
         2'b01: begin
            dmem_wdata = {2{read_data2_pype2[15:0]}};
            dmem_wstrb = 4'b0011 << ALU_co_pype[1:0];
         end
         default: begin
            dmem_wdata = read_data2_pype2;
            dmem_wstrb = 4'b1111;
         end
      endcase
      dmem_req  = req & rst;
      mem_stall = stall & rst;
   end

   // Load lane select and extension; HOLD reads the buffered word
   always_comb begin
      word     = (state_q == S_HOLD) ? rbuf_q : dmem_rdata;
      byte_sel = word[{ALU_co_pype[1:0], 3'b000} +: 8];
      half_sel = ALU_co_pype[1] ? word[31:16] : word[15:0];
      case (funct3_pype2)
         3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
         3'b010:  ld_ext = word;
         3'b100:  ld_ext = {24'h0, byte_sel};
         3'b101:  ld_ext = {16'h0, half_sel};
         default: ld_ext = 32'h0;
      endcase
   end

   // MEM/WB payload: frozen on stall or keep, bubbled on nop or a faulted access
   always_comb begin
      alu_d  = alu_q;
      ld_d   = ld_q;
      pc_d   = pc_q;
      wreg_d = wreg_q;
      wbc_d  = wbc_q;
      bubble = nop | ((state_q == S_IDLE) & memop & misaligned) | timeout |
               ((state_q == S_HOLD) & hold_err_q);
      if (!stall && !keep) begin
         if (bubble) begin
            alu_d  = '0;
            ld_d   = '0;
            pc_d   = '0;
            wreg_d = '0;
            wbc_d  = '0;
         end else begin
            alu_d  = ALU_co_pype;
            ld_d   = MemRW_pype2[1] ? ld_ext : 32'h0;
            pc_d   = PCp4_pype2;
            wreg_d = WReg_pype2;
            wbc_d  = writeback_control_pype2;
         end
      end
      mis_d     = mis_evt;
      bus_err_d = timeout;
      fault_d   = (mis_evt | timeout) ? ALU_co_pype : fault_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rbuf_q     <= '0;
         hold_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rbuf_q     <= rbuf_d;
         hold_err_q <= hold_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         alu_q     <= '0;
         ld_q      <= '0;
         pc_q      <= '0;
         wreg_q    <= '0;
         wbc_q     <= '0;
         mis_q     <= 1'b0;
         bus_err_q <= 1'b0;
         fault_q   <= '0;
      end else begin
         alu_q     <= alu_d;
         ld_q      <= ld_d;
         pc_q      <= pc_d;
         wreg_q    <= wreg_d;
         wbc_q     <= wbc_d;
         mis_q     <= mis_d;
         bus_err_q <= bus_err_d;
         fault_q   <= fault_d;
      end
   end

   assign ALU_co_pype3            = alu_q;
   assign load_data_pype3         = ld_q;
   assign PCp4_pype3              = pc_q;
   assign WReg_pype3              = wreg_q;
   assign writeback_control_pype3 = wbc_q;
   assign mem_misalign            = mis_q;
   assign mem_bus_error           = bus_err_q;
   assign mem_fault_addr          = fault_q;
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed corner cases then random traffic against a
// word-array memory model with random wait states and hazard holds.
module tb_mem_access;
   localparam int unsigned TO = 16;

   logic        clk, rst, keep, nop;
   logic [31:0] ALU_co_pype, read_data2_pype2, PCp4_pype2;
   logic [4:0]  WReg_pype2;
   logic [2:0]  writeback_control_pype2, funct3_pype2;
   logic [1:0]  MemRW_pype2, dsize_pype2;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;
   logic [31:0] ALU_co_pype3, load_data_pype3, PCp4_pype3;
   logic [4:0]  WReg_pype3;
   logic [2:0]  writeback_control_pype3;
   logic        mem_stall, mem_misalign, mem_bus_error;
   logic [31:0] mem_fault_addr;

   int tests = 0;
   int fails = 0;
   logic [31:0] mem [16];
   logic [31:0] e_alu, e_ld, e_pc, e_fault;
   logic [4:0]  e_wreg;
   logic [2:0]  e_wbc;
   int          nstall;
   logic [31:0] o_wdata, o_ld;
   logic [3:0]  o_wstrb;
   logic        o_we;
   logic [2:0]  o_wbc;

   mem_access #(.BUS_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .keep(keep), .nop(nop),
      .ALU_co_pype(ALU_co_pype), .read_data2_pype2(read_data2_pype2),
      .PCp4_pype2(PCp4_pype2), .WReg_pype2(WReg_pype2),
      .writeback_control_pype2(writeback_control_pype2), .funct3_pype2(funct3_pype2),
      .MemRW_pype2(MemRW_pype2), .dsize_pype2(dsize_pype2),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .ALU_co_pype3(ALU_co_pype3), .load_data_pype3(load_data_pype3),
      .PCp4_pype3(PCp4_pype3), .WReg_pype3(WReg_pype3),
      .writeback_control_pype3(writeback_control_pype3),
      .mem_stall(mem_stall), .mem_misalign(mem_misalign),
      .mem_bus_error(mem_bus_error), .mem_fault_addr(mem_fault_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_alu"}, ALU_co_pype3, e_alu);
      check({tag, "_ld"}, load_data_pype3, e_ld);
      check({tag, "_pc"}, PCp4_pype3, e_pc);
      check({tag, "_wreg"}, 32'(WReg_pype3), 32'(e_wreg));
      check({tag, "_wbc"}, 32'(writeback_control_pype3), 32'(e_wbc));
   endtask

   function automatic logic is_misaligned(input logic [1:0] ds, input logic [31:0] a);
      return ((ds == 2'd1) && (a % 2 != 0)) || ((ds == 2'd2) && (a % 4 != 0));
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [31:0] a,
                                            input logic [2:0] f3);
      logic [31:0] b, h;
      b = (w >> ((a % 4) * 8)) & 32'hFF;
      h = (w >> ((a % 4) / 2 * 16)) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 32'h80) ? b - 32'h100 : b;
         3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
         3'b010:  return w;
         3'b100:  return b;
         3'b101:  return h;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [3:0] exp_strb(input logic [1:0] ds, input logic [31:0] a);
      case (ds)
         2'd0:    return 4'(32'd1 << (a % 4));
         2'd1:    return 4'(32'd3 << (a % 4));
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [1:0] ds, input logic [31:0] sd);
      case (ds)
         2'd0:    return (sd & 32'hFF) * 32'h0101_0101;
         2'd1:    return (sd & 32'hFFFF) * 32'h0001_0001;
         default: return sd;
      endcase
   endfunction

   // One instruction through the stage; lat = cycles until ready (-1 = never),
   // keepn = cycles keep is held from completion, nop_fin = bubble on the update edge.
   task automatic do_op(input logic [1:0] rw, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input int lat, input int keepn,
                        input logic nop_fin);
      logic [1:0]  ds;
      logic        mis, memop, rdy, comp, tmo;
      logic [31:0] pc, rword, wd;
      logic [4:0]  wr;
      logic [2:0]  wbc;
      logic [3:0]  st, idx;
      int          waited;
      ds    = (f3[1:0] == 2'b11) ? 2'b10 : f3[1:0];
      pc    = $urandom;
      wr    = 5'($urandom);
      wbc   = 3'($urandom_range(1, 7));
      memop = (rw != 2'b00);
      mis   = memop && is_misaligned(ds, addr);
      idx   = addr[5:2];
      rword = mem[idx];
      wd    = exp_wdata(ds, sd);
      st    = exp_strb(ds, addr);
      ALU_co_pype = addr; read_data2_pype2 = sd; PCp4_pype2 = pc; WReg_pype2 = wr;
      writeback_control_pype2 = wbc; funct3_pype2 = f3; MemRW_pype2 = rw; dsize_pype2 = ds;
      nstall = 0; waited = 0; comp = 1'b0; tmo = 1'b0;
      while (!comp) begin
         rdy  = memop && !mis && (waited == lat);
         tmo  = memop && !mis && !rdy && (waited == int'(TO) - 1);
         comp = !memop || mis || rdy || tmo;
         dmem_ready = rdy;
         dmem_rdata = rdy ? rword : $urandom;
         keep = comp && (keepn > 0);
         nop  = comp && (keepn == 0) && nop_fin;
         #1;
         check1("stall", mem_stall, memop && !mis && !comp);
         if (!tmo) check1("req", dmem_req, memop && !mis);
         if (memop && !mis && !tmo) begin
            check("addr", dmem_addr, {addr[31:2], 2'b00});
            check1("we", dmem_we, rw[0]);
            if (rw[0]) begin
               check("wdata", dmem_wdata, wd);
               check("wstrb", 32'(dmem_wstrb), 32'(st));
            end
            if (waited == 0) begin
               o_wdata = dmem_wdata; o_wstrb = dmem_wstrb; o_we = dmem_we;
            end
         end
         check("frozen_ld", load_data_pype3, e_ld);
         check("frozen_wbc", 32'(writeback_control_pype3), 32'(e_wbc));
         if (mem_stall) nstall++;
         if (rdy && rw[0]) begin
            for (int i = 0; i < 4; i++)
               if (st[i]) mem[idx][8*i +: 8] = wd[8*i +: 8];
         end
         step();
         waited++;
      end
      dmem_ready = 1'b0;
      for (int k = 1; k <= keepn; k++) begin
         keep = (k < keepn);
         nop  = (k == keepn) && nop_fin;
         dmem_rdata = $urandom;
         #1;
         check1("hold_req", dmem_req, 1'b0);
         check1("hold_stall", mem_stall, 1'b0);
         check("hold_ld", load_data_pype3, e_ld);
         check("hold_alu", ALU_co_pype3, e_alu);
         step();
      end
      keep = 1'b0; nop = 1'b0;
      if (mis || tmo || nop_fin) begin
         e_alu = '0; e_ld = '0; e_pc = '0; e_wreg = '0; e_wbc = '0;
      end else begin
         e_alu = addr; e_pc = pc; e_wreg = wr; e_wbc = wbc;
         e_ld  = (rw == 2'b10) ? load_ext(rword, addr, f3) : 32'h0;
      end
      if (mis || tmo) e_fault = addr;
      check_regs("op");
      check1("misalign", mem_misalign, mis);
      check1("bus_error", mem_bus_error, tmo);
      check("fault_addr", mem_fault_addr, e_fault);
      o_ld = load_data_pype3; o_wbc = writeback_control_pype3;
      // follow-on non-memory instruction: pulses must end, payload passes through
      MemRW_pype2 = 2'b00; ALU_co_pype = $urandom; PCp4_pype2 = $urandom;
      WReg_pype2 = 5'($urandom); writeback_control_pype2 = 3'($urandom);
      funct3_pype2 = 3'($urandom); dsize_pype2 = 2'($urandom); dmem_rdata = $urandom;
      #1;
      check1("idle_req", dmem_req, 1'b0);
      check1("idle_stall", mem_stall, 1'b0);
      step();
      e_alu = ALU_co_pype; e_pc = PCp4_pype2; e_wreg = WReg_pype2;
      e_wbc = writeback_control_pype2; e_ld = 32'h0;
      check_regs("idle");
      check1("idle_misalign", mem_misalign, 1'b0);
      check1("idle_bus_error", mem_bus_error, 1'b0);
   endtask

   initial begin
      logic [1:0]  rw;
      logic [2:0]  f3;
      logic [31:0] a, sd;
      int          sz, lat, kn;
      logic        uns, nf, mis;
      rst = 1'b0; keep = 1'b0; nop = 1'b0;
      ALU_co_pype = '0; read_data2_pype2 = '0; PCp4_pype2 = '0; WReg_pype2 = '0;
      writeback_control_pype2 = '0; funct3_pype2 = '0; MemRW_pype2 = '0; dsize_pype2 = '0;
      dmem_ready = 1'b0; dmem_rdata = '0;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      e_alu = '0; e_ld = '0; e_pc = '0; e_wreg = '0; e_wbc = '0; e_fault = '0;
      step();
      step();
      check_regs("reset");
      check1("reset_misalign", mem_misalign, 1'b0);
      check1("reset_bus_error", mem_bus_error, 1'b0);
      check("reset_fault", mem_fault_addr, 32'h0);
      rst = 1'b1;

      // LB sign-extended from lane 3, zero-wait
      mem[0] = 32'h80FF_FF00;
      do_op(2'b10, 3'b000, 32'h0000_1003, 32'h0, 0, 0, 1'b0);
      check("lb_stalls", 32'(nstall), 32'd0);
      check("lb_data", o_ld, 32'hFFFF_FF80);

      // SH to upper half
      do_op(2'b01, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 0, 0, 1'b0);
      check("sh_wdata", o_wdata, 32'hBEEF_BEEF);
      check("sh_wstrb", 32'(o_wstrb), 32'h0000_000C);
      check1("sh_we", o_we, 1'b1);

      // LW with three wait cycles
      do_op(2'b10, 3'b010, 32'h0000_0010, 32'h0, 3, 0, 1'b0);
      check("lw_wait_stalls", 32'(nstall), 32'd3);

      // misaligned LW
      do_op(2'b10, 3'b010, 32'h0000_0006, 32'h0, 0, 0, 1'b0);
      check("misal_stalls", 32'(nstall), 32'd0);
      check("misal_wbc", 32'(o_wbc), 32'd0);

      // LW that never gets ready
      do_op(2'b10, 3'b010, 32'h0000_0020, 32'h0, -1, 0, 1'b0);
      check("timeout_stalls", 32'(nstall), 32'd15);

      // LHU completing under keep for two cycles
      mem[2] = 32'h9ABC_1234;
      do_op(2'b10, 3'b101, 32'h0000_000A, 32'h0, 1, 2, 1'b0);
      check("lhu_hold_data", o_ld, 32'h0000_9ABC);

      // reset in the middle of a waiting access
      ALU_co_pype = 32'h30; MemRW_pype2 = 2'b10; dsize_pype2 = 2'b10; funct3_pype2 = 3'b010;
      WReg_pype2 = 5'd7; writeback_control_pype2 = 3'd5;
      #1;
      check1("rstw_stall0", mem_stall, 1'b1);
      step();
      check1("rstw_req1", dmem_req, 1'b1);
      step();
      rst = 1'b0; MemRW_pype2 = 2'b00;
      #1;
      check1("rstw_req_in_reset", dmem_req, 1'b0);
      step();
      rst = 1'b1;
      #1;
      e_alu = '0; e_ld = '0; e_pc = '0; e_wreg = '0; e_wbc = '0; e_fault = '0;
      check1("rstw_req_after", dmem_req, 1'b0);
      check1("rstw_stall_after", mem_stall, 1'b0);
      check_regs("rstw");
      check1("rstw_bus_error", mem_bus_error, 1'b0);

      // random traffic
      for (int n = 0; n < 150; n++) begin
         rw  = 2'($urandom_range(0, 2));
         sz  = int'($urandom_range(0, 2));
         uns = (rw == 2'b10) && (sz < 2) && ($urandom_range(0, 1) == 1);
         f3  = {uns, 2'(sz)};
         a   = $urandom;
         sd  = (sz == 0) ? ($urandom & 32'hFF) : (sz == 1) ? ($urandom & 32'hFFFF) : $urandom;
         lat = int'($urandom_range(0, 4));
         kn  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         mis = (rw != 2'b00) && is_misaligned(2'(sz), a);
         nf  = !mis && ($urandom_range(0, 5) == 0);
         do_op(rw, f3, a, sd, lat, kn, nf);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
